// File: rtl/mult_pkg.sv
// mult_pkg: shared helpers for the pipelined multiplier.
//   DEFAULT_WIDTH / DEFAULT_BITS_PER_STAGE : default parameter values
//   stage_count() : number of partial-product accumulate stages
//   latency()     : accept-edge to out_valid latency in cycles
//   params_ok()   : static legality check for a WIDTH / BITS_PER_STAGE pair
package mult_pkg;

    localparam int DEFAULT_WIDTH          = 8;
    localparam int DEFAULT_BITS_PER_STAGE = 2;

    function automatic int stage_count(input int width, input int bits_per_stage);
        return width / bits_per_stage;
    endfunction

    // Input register plus S accumulate stages; the output register is loaded
    // on the same edge that completes the last accumulate stage's successor.
    function automatic int latency(input int width, input int bits_per_stage);
        return stage_count(width, bits_per_stage) + 1;
    endfunction

    function automatic bit params_ok(input int width, input int bits_per_stage);
        return (width >= 2) && (bits_per_stage >= 1) &&
               ((width % bits_per_stage) == 0);
    endfunction

endpackage

// File: rtl/mult_pp_stage.sv
// mult_pp_stage: one accumulate stage of the multiplier pipeline.
// Adds |a| times the CHUNK_IDX-th BITS_PER_STAGE-bit chunk of |b|, shifted
// into place, to the running 2*WIDTH-bit accumulator, and forwards the beat.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_adv               pipeline advance; all registers hold when low
//   i_valid/o_valid     beat valid in / out
//   i_a_mag/o_a_mag     multiplicand magnitude
//   i_b_mag/o_b_mag     multiplier magnitude
//   i_neg/o_neg         result must be negated at the output
//   i_acc/o_acc         partial-sum accumulator
module mult_pp_stage
    import mult_pkg::*;
#(
    parameter int WIDTH          = DEFAULT_WIDTH,
    parameter int BITS_PER_STAGE = DEFAULT_BITS_PER_STAGE,
    parameter int CHUNK_IDX      = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_adv,
    input  logic                 i_valid,
    input  logic [WIDTH-1:0]     i_a_mag,
    input  logic [WIDTH-1:0]     i_b_mag,
    input  logic                 i_neg,
    input  logic [2*WIDTH-1:0]   i_acc,
    output logic                 o_valid,
    output logic [WIDTH-1:0]     o_a_mag,
    output logic [WIDTH-1:0]     o_b_mag,
    output logic                 o_neg,
    output logic [2*WIDTH-1:0]   o_acc
);

    localparam int SHIFT = CHUNK_IDX * BITS_PER_STAGE;

    logic [BITS_PER_STAGE-1:0] w_chunk;
    logic [2*WIDTH-1:0]        w_a_ext;
    logic [2*WIDTH-1:0]        w_chunk_ext;
    logic [2*WIDTH-1:0]        w_pp;

    logic                      r_valid;
    logic [WIDTH-1:0]          r_a_mag;
    logic [WIDTH-1:0]          r_b_mag;
    logic                      r_neg;
    logic [2*WIDTH-1:0]        r_acc;

    assign w_chunk     = i_b_mag[SHIFT +: BITS_PER_STAGE];
    assign w_a_ext     = {{WIDTH{1'b0}}, i_a_mag};
    assign w_chunk_ext = {{(2*WIDTH-BITS_PER_STAGE){1'b0}}, w_chunk};
    // Never overflows 2*WIDTH bits: the full sum is at most (2^W-1)^2.
    assign w_pp        = (w_a_ext * w_chunk_ext) << SHIFT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_a_mag <= '0;
            r_b_mag <= '0;
            r_neg   <= 1'b0;
            r_acc   <= '0;
        end else if (i_adv) begin
            r_valid <= i_valid;
            r_a_mag <= i_a_mag;
            r_b_mag <= i_b_mag;
            r_neg   <= i_neg;
            r_acc   <= i_acc + w_pp;
        end
    end

    assign o_valid = r_valid;
    assign o_a_mag = r_a_mag;
    assign o_b_mag = r_b_mag;
    assign o_neg   = r_neg;
    assign o_acc   = r_acc;

endmodule

// File: rtl/mult_pipe.sv
// mult_pipe: pipelined WIDTH x WIDTH multiplier, valid/ready stream in and
// out, per-beat signed/unsigned selection, global enable.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   ena             global enable; low freezes every pipeline register
//   in_valid        operand beat valid
//   in_ready        beat accepted on this edge if in_valid (combinational)
//   in_a, in_b      multiplicand / multiplier
//   in_signed       1 = operands are two's complement
//   out_valid       out_product holds a result
//   out_ready       consumer takes the result this cycle
//   out_product     2*WIDTH-bit product (two's complement for signed beats)
// Structure: R0 (magnitudes + sign), S accumulate stages, RO (sign restore).
module mult_pipe
    import mult_pkg::*;
#(
    parameter int WIDTH          = DEFAULT_WIDTH,
    parameter int BITS_PER_STAGE = DEFAULT_BITS_PER_STAGE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product
);

    localparam int S = stage_count(WIDTH, BITS_PER_STAGE);

    generate
        if (!params_ok(WIDTH, BITS_PER_STAGE)) begin : g_bad_params
            $error("mult_pipe: WIDTH must be >= 2 and a multiple of BITS_PER_STAGE");
        end
    endgenerate

    logic               w_adv;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag_in;
    logic [WIDTH-1:0]   w_b_mag_in;

    // Input register R0
    logic               r_in_valid;
    logic [WIDTH-1:0]   r_a_mag;
    logic [WIDTH-1:0]   r_b_mag;
    logic               r_neg;

    // Output register RO
    logic               r_out_valid;
    logic [2*WIDTH-1:0] r_out_product;

    // Stage chain: index 0 is fed by R0, index S is the last stage output.
    logic               w_valid [0:S];
    logic [WIDTH-1:0]   w_a_mag [0:S];
    logic [WIDTH-1:0]   w_b_mag [0:S];
    logic               w_neg   [0:S];
    logic [2*WIDTH-1:0] w_acc   [0:S];

    // A held result blocks everything behind it; the pipeline never compresses.
    assign w_adv    = ena && !(r_out_valid && !out_ready);
    assign in_ready = w_adv;

    // Magnitudes: negating the most negative value yields 2^(W-1), which is
    // exact as a WIDTH-bit unsigned number.
    assign w_a_neg    = in_signed && in_a[WIDTH-1];
    assign w_b_neg    = in_signed && in_b[WIDTH-1];
    assign w_a_mag_in = w_a_neg ? (-in_a) : in_a;
    assign w_b_mag_in = w_b_neg ? (-in_b) : in_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_valid <= 1'b0;
            r_a_mag    <= '0;
            r_b_mag    <= '0;
            r_neg      <= 1'b0;
        end else if (w_adv) begin
            r_in_valid <= in_valid;
            r_a_mag    <= w_a_mag_in;
            r_b_mag    <= w_b_mag_in;
            r_neg      <= w_a_neg ^ w_b_neg;
        end
    end

    assign w_valid[0] = r_in_valid;
    assign w_a_mag[0] = r_a_mag;
    assign w_b_mag[0] = r_b_mag;
    assign w_neg[0]   = r_neg;
    assign w_acc[0]   = '0;

    genvar gi;
    generate
        for (gi = 0; gi < S; gi++) begin : g_stage
            mult_pp_stage #(
                .WIDTH          (WIDTH),
                .BITS_PER_STAGE (BITS_PER_STAGE),
                .CHUNK_IDX      (gi)
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_adv   (w_adv),
                .i_valid (w_valid[gi]),
                .i_a_mag (w_a_mag[gi]),
                .i_b_mag (w_b_mag[gi]),
                .i_neg   (w_neg[gi]),
                .i_acc   (w_acc[gi]),
                .o_valid (w_valid[gi+1]),
                .o_a_mag (w_a_mag[gi+1]),
                .o_b_mag (w_b_mag[gi+1]),
                .o_neg   (w_neg[gi+1]),
                .o_acc   (w_acc[gi+1])
            );
        end
    endgenerate

    // Sign restore; the true product always fits in 2*WIDTH bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_product <= '0;
        end else if (w_adv) begin
            r_out_valid   <= w_valid[S];
            r_out_product <= w_neg[S] ? (-w_acc[S]) : w_acc[S];
        end
    end

    assign out_valid   = r_out_valid;
    assign out_product = r_out_product;

endmodule

// File: doc/mult_pipe.md
# mult_pipe

Parametrised, pipelined W×W multiplier with a valid/ready stream interface and a per-transaction signed/unsigned mode. It generalises the fixed 4-bit pipelined multiplier to any even operand width and a configurable pipeline depth, adding backpressure, a global enable and two's-complement support. It sits between an operand source (switch/IO capture logic or an upstream stream) and a result consumer (display driver or downstream stream).

## Interface
- WIDTH, 8, operand width in bits; must be ≥2 and a multiple of BITS_PER_STAGE.
- BITS_PER_STAGE, 2, multiplier bits of operand b consumed per pipeline stage.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  global enable; low freezes the pipeline.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_signed  in  1  1 = treat in_a and in_b as two's complement; 0 = unsigned.
- out_valid  out  1  out_product is valid.
- out_ready  in  1  consumer accepts the result this cycle.
- out_product  out  2*WIDTH  product; two's complement if the beat was signed.

## Operation
- S = WIDTH/BITS_PER_STAGE partial-product stages.
- Pipeline registers: input stage (R0), S accumulate stages (R1..RS), output register (RO). Each carries a valid bit.
- Advance condition: adv = ena && !(out_valid && !out_ready). All stages move together on adv; every register holds otherwise.
- in_ready = adv (combinational). A beat is accepted on an edge where in_valid && in_ready.
- R0 captures |a| and |b| as WIDTH-bit unsigned magnitudes plus neg = in_signed && (a[MSB] xor b[MSB]). Unsigned beats pass a and b through unchanged with neg = 0.
- Rk adds (|a| × chunk k-1 of |b|) << ((k-1)·BITS_PER_STAGE) to a 2·WIDTH-bit accumulator. |a|, the remaining |b| and neg travel with the beat.
- RO = neg ? −acc : acc, truncated to 2·WIDTH bits. This is always exact:
  - signed range is [−2^(2W−2)+2^(W−1), 2^(2W−2)];
  - unsigned maximum is (2^W−1)².
- −2^(W−1) has magnitude 2^(W−1), which is representable as WIDTH-bit unsigned. No special case.
- A bubble (stage valid = 0) advances like data. Bubbles are not compressed.
- in_signed is sampled per beat. Mixed signed/unsigned streams are legal back-to-back.

## Timing
- Latency: a beat accepted at edge t appears with out_valid = 1 after edge t+S+1, provided adv is high throughout. With default parameters the latency is 5.
- Throughput: one beat per cycle while out_ready = 1 and ena = 1.
- Stall: out_valid && !out_ready holds all stages. out_product stays stable and in_ready = 0 until the handshake completes.
- ena = 0: identical to a stall; in_ready = 0 and all state holds.
- A simultaneous out handshake and new input acceptance in the same cycle is legal; both complete.
- Reset values while rst_n = 0 and after its release:
  - all valid bits = 0 and all data registers = 0;
  - out_valid = 0 and out_product = 0;
  - in_ready = ena.
- Reset asserted mid-operation discards every in-flight beat immediately. No partial result is ever emitted.

## Structure
- Package mult_pkg holds:
  - the functions stage_count(WIDTH, BITS_PER_STAGE) and latency(...) = stage_count+1;
  - a static parameter check that WIDTH % BITS_PER_STAGE == 0.
- Sub-module mult_pp_stage implements one accumulate stage: register slice plus the shifted partial-product add, with the chunk index as a parameter. The top level generates S instances.
- The top level owns R0, RO, the sign logic and the adv/in_ready control.

## Test plan
- Unsigned: in_a=13, in_b=11, in_signed=0, out_ready=1 → out_product=0x008F with out_valid high exactly 5 cycles after acceptance.
- Signed: −3 × 7 (0xFD, 0x07, in_signed=1) → 0xFFEB. Corner cases: −128 × −128 → 0x4000; −128 × 127 → 0xC080; unsigned 255 × 255 → 0xFE01.
- Streaming: 20 back-to-back random beats with mixed in_signed → results in order, one per cycle, all matching the reference model.
- Backpressure/ena: hold out_ready=0 for 3 cycles mid-stream, then toggle ena low for 2 cycles → out_product is stable, in_ready=0 during the hold, and no beat is lost or duplicated.
- Reset: assert rst_n=0 asynchronously with 3 beats in flight → out_valid=0 and out_product=0 immediately, and no stale result appears after release.
- Parameter sweep: WIDTH=4/BITS_PER_STAGE=1 (latency 5) and WIDTH=16/BITS_PER_STAGE=4 (latency 5) → exhaustive (W=4) or random (W=16) agreement with the model.
